// File: rtl/mem_stage_periph_pkg.sv
// mem_stage_periph_pkg: peripheral offsets, TCON bit indices and default window base
package mem_stage_periph_pkg;
  localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;
  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_SWITCH  = 8'h10;
  localparam logic [7:0] OFF_DIGI    = 8'h14;
  localparam logic [7:0] OFF_SYSTICK = 8'h18;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;
  function automatic logic periph_hit(input logic [31:0] a, input logic [31:0] base, input logic [7:0] off);
    return (a & ~32'h3) == base + {24'b0, off};
  endfunction
endpackage

// File: rtl/mem_stage_periph_sync2.sv
// sync2: W-bit two-flop synchroniser with asynchronous active-high reset
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, s1} <= '0;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/mem_stage_periph.sv
// mem_stage_periph: MEM-stage data RAM plus timer/LED/7-seg/switch/systick peripherals
// Define MEM_SYSTICK_EN to include the free-running SYSTICK counter at offset 0x18.
module mem_stage_periph
  import mem_stage_periph_pkg::*;
#(
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] th, tl, systick_rd;
  logic [2:0]  tcon;
  logic [7:0]  sw_s;
  logic ram_hit, s_th, s_tl, s_tcon, s_led, s_sw, s_digi, s_tick;
  assign ram_hit = addr < 32'(RAM_WORDS * 4);
  assign s_th    = !ram_hit && periph_hit(addr, PERIPH_BASE, OFF_TH);
  assign s_tl    = !ram_hit && periph_hit(addr, PERIPH_BASE, OFF_TL);
  assign s_tcon  = !ram_hit && periph_hit(addr, PERIPH_BASE, OFF_TCON);
  assign s_led   = !ram_hit && periph_hit(addr, PERIPH_BASE, OFF_LED);
  assign s_sw    = !ram_hit && periph_hit(addr, PERIPH_BASE, OFF_SWITCH);
  assign s_digi  = !ram_hit && periph_hit(addr, PERIPH_BASE, OFF_DIGI);
  assign s_tick  = !ram_hit && periph_hit(addr, PERIPH_BASE, OFF_SYSTICK);
  assign irq = tcon[TCON_ST] & tcon[TCON_IE];
  sync2 #(.W(8)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (switch),
    .q    (sw_s)
  );
  always_ff @(posedge clk)
    if (mem_write && ram_hit) ram[addr[AW+1:2]] <= wr_data;
  // software writes come last so they override timer increment/reload and status set
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      led  <= '0;
      digi <= '0;
    end else begin
      if (tcon[TCON_EN]) begin
        tl <= (&tl) ? th : tl + 32'd1;
        if (&tl && tcon[TCON_IE]) tcon[TCON_ST] <= 1'b1;
      end
      if (mem_write && s_th)   th   <= wr_data;
      if (mem_write && s_tl)   tl   <= wr_data;
      if (mem_write && s_tcon) tcon <= wr_data[2:0];
      if (mem_write && s_led)  led  <= wr_data[7:0];
      if (mem_write && s_digi) digi <= wr_data[11:0];
    end
`ifdef MEM_SYSTICK_EN
  logic [31:0] systick;
  always_ff @(posedge clk or posedge reset)
    if (reset) systick <= '0;
    else systick <= systick + 32'd1;
  assign systick_rd = systick;
`else
  assign systick_rd = '0;
`endif
  always_comb
    rd_data = !mem_read ? 32'd0 :
              ram_hit   ? ram[addr[AW+1:2]] :
              s_th      ? th :
              s_tl      ? tl :
              s_tcon    ? {29'b0, tcon} :
              s_led     ? {24'b0, led} :
              s_sw      ? {24'b0, sw_s} :
              s_digi    ? {20'b0, digi} :
              s_tick    ? systick_rd : 32'd0;
endmodule

// File: tb/tb_mem_stage_periph.sv
// tb_mem_stage_periph: directed stimulus checked against a behavioural model every cycle
module tb_mem_stage_periph;
  localparam logic [31:0] B = 32'h4000_0000;
  logic clk = 0, reset = 1, mem_read = 0, mem_write = 0, irq;
  logic [31:0] addr = 0, wr_data = 0, rd_data, t0, t1;
  logic [7:0] switch = 0, led;
  logic [11:0] digi;
  int checks = 0, errors = 0;

  mem_stage_periph dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .switch(switch),
    .led(led), .digi(digi), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] th, tl, tick;
    logic [2:0]  tcon;
    logic [7:0]  led, sw_1ago, sw_2ago;
    logic [11:0] digi;
  } ms_t;
  ms_t m;
  logic [31:0] mram [256];

  function automatic ms_t nxt(ms_t s, logic w, logic [31:0] a, logic [31:0] d, logic [7:0] sw);
    ms_t n;
    logic [31:0] off;
    n = s;
    off = {a[31:2], 2'b00} - B;
    n.tick = s.tick + 1;
    n.sw_2ago = s.sw_1ago;
    n.sw_1ago = sw;
    if (s.tcon[0]) begin
      n.tl = (s.tl == 32'hFFFF_FFFF) ? s.th : s.tl + 1;
      if (s.tl == 32'hFFFF_FFFF && s.tcon[1]) n.tcon[2] = 1'b1;
    end
    if (w && a >= 1024) begin
      if (off == 0) n.th = d;
      if (off == 4) n.tl = d;
      if (off == 8) n.tcon = d[2:0];
      if (off == 12) n.led = d[7:0];
      if (off == 20) n.digi = d[11:0];
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(ms_t s, logic r, logic [31:0] a);
    logic [31:0] off;
    off = {a[31:2], 2'b00} - B;
    if (!r) return 0;
    if (a < 1024) return mram[a[9:2]];
    if (off == 0) return s.th;
    if (off == 4) return s.tl;
    if (off == 8) return 32'(s.tcon);
    if (off == 12) return 32'(s.led);
    if (off == 16) return 32'(s.sw_2ago);
    if (off == 20) return 32'(s.digi);
`ifdef MEM_SYSTICK_EN
    if (off == 24) return s.tick;
`endif
    return 0;
  endfunction

  always @(posedge clk or posedge reset)
    m <= reset ? '0 : nxt(m, mem_write, addr, wr_data, switch);
  always @(posedge clk)
    if (mem_write && addr < 1024) mram[addr[9:2]] <= wr_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset) begin
      chk("rd_data", rd_data, exp_rd(m, mem_read, addr));
      chk("led", 32'(led), 32'(m.led));
      chk("digi", 32'(digi), 32'(m.digi));
      chk("irq", 32'(irq), 32'(m.tcon[2] & m.tcon[1]));
    end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    mem_read = r;
    mem_write = w;
    addr = a;
    wr_data = d;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(0, 1, a, d);
    step();
    drive(0, 0, 0, 0);
  endtask
  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    drive(1, 0, a, 0);
    #1;
    chk(nm, rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    chk("rst led", 32'(led), 0);
    chk("rst digi", 32'(digi), 0);
    chk("rst irq", 32'(irq), 0);
    rd_chk("rst tl", B + 4, 0);
    reset = 0;
    rd_chk("rst tcon", B + 8, 0);
    wr(32'h10, 32'hDEAD_BEEF);
    rd_chk("ram", 32'h10, 32'hDEAD_BEEF);
    rd_chk("ram low bits", 32'h13, 32'hDEAD_BEEF);
    drive(0, 0, 32'h10, 0);
    #1 chk("ram no read", rd_data, 0);
    wr(B + 0, 32'hFFFF_FFFD);
    wr(B + 4, 32'hFFFF_FFFE);
    wr(B + 8, 3);
    step();
    rd_chk("tl inc", B + 4, 32'hFFFF_FFFF);
    chk("irq pre", 32'(irq), 0);
    step();
    rd_chk("tl reload", B + 4, 32'hFFFF_FFFD);
    chk("irq set", 32'(irq), 1);
    rd_chk("tcon status", B + 8, 7);
    wr(B + 8, 3);
    chk("irq clear", 32'(irq), 0);
    step();
    rd_chk("tl at ovf", B + 4, 32'hFFFF_FFFF);
    wr(B + 8, 3);
    chk("ovf+tcon irq", 32'(irq), 0);
    rd_chk("ovf+tcon tl", B + 4, 32'hFFFF_FFFD);
    rd_chk("ovf+tcon st", B + 8, 3);
    wr(B + 4, 5);
    rd_chk("tl wr wins", B + 4, 5);
    wr(B + 4, 32'hFFFF_FFFF);
    wr(B + 0, 32'h100);
    rd_chk("reload old th", B + 4, 32'hFFFF_FFFD);
    rd_chk("th new", B + 0, 32'h100);
    wr(B + 8, 0);
    chk("irq off", 32'(irq), 0);
    switch = 8'hA5;
    rd_chk("sw 0 edges", B + 16, 0);
    step();
    rd_chk("sw 1 edge", B + 16, 0);
    step();
    rd_chk("sw 2 edges", B + 16, 32'hA5);
    rd_chk("unmapped rd", B + 32, 0);
    wr(B + 32, 32'hFFFF_FFFF);
    wr(B + 16, 0);
    rd_chk("sw read-only", B + 16, 32'hA5);
    rd_chk("th kept", B + 0, 32'h100);
    rd_chk("led kept", B + 12, 0);
    wr(B + 12, 32'h1FF);
    chk("led", 32'(led), 32'hFF);
    rd_chk("led rd", B + 12, 32'hFF);
    wr(B + 20, 32'hF3F);
    chk("digi", 32'(digi), 32'hF3F);
    rd_chk("digi rd", B + 20, 32'hF3F);
    wr(B + 12, 32'h12);
    drive(1, 1, B + 12, 32'h34);
    #1 chk("rww old", rd_data, 32'h12);
    step();
    chk("rww new", 32'(led), 32'h34);
    drive(1, 0, B + 24, 0);
    #1 t0 = rd_data;
    repeat (5) step();
    t1 = rd_data;
`ifdef MEM_SYSTICK_EN
    chk("systick delta", t1 - t0, 5);
`else
    chk("systick t0", t0, 0);
    chk("systick t1", t1, 0);
`endif
    wr(B + 8, 3);
    step();
    step();
    chk("irq before rst", 32'(irq), 1);
    drive(1, 0, B + 4, 0);
    #2 reset = 1;
    #1;
    chk("arst led", 32'(led), 0);
    chk("arst digi", 32'(digi), 0);
    chk("arst irq", 32'(irq), 0);
    chk("arst tl", rd_data, 0);
    step();
    reset = 0;
    step();
    rd_chk("post rst tcon", B + 8, 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
